// File: rtl/tick_gen_pkg.sv
// Shared constants for the multi-channel tick/clock-enable generator.
package tick_gen_pkg;

  localparam logic        MODE_PULSE  = 1'b0;
  localparam logic        MODE_SQUARE = 1'b1;
  localparam int unsigned DEF_CW      = 32;

endpackage

// File: rtl/tick_gen_chan.sv
// One tick channel: wrap counter, active/shadow divisor and mode, registered tick/sq outputs.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int unsigned   CW       = DEF_CW,
  parameter logic [CW-1:0] DEF_DIV  = CW'(99999),
  parameter logic          DEF_MODE = MODE_PULSE
) (
  input  logic          mclk,
  input  logic          clr_n,
  input  logic          en,
  input  logic          sync,
  input  logic          we,
  input  logic [CW-1:0] wdiv,
  input  logic          wmode,
  output logic          tick,
  output logic          sq,
  output logic          pend
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_act_q, div_act_d;
  logic [CW-1:0] div_shd_q, div_shd_d;
  logic          mode_q, mode_d;
  logic          mode_shd_q, mode_shd_d;
  logic          pend_q, pend_d;
  logic          tick_q, tick_d;
  logic          sq_q, sq_d;

  logic          term;
  logic [CW-1:0] next_div;
  logic          next_mode;

  assign term = en && (cnt_q == div_act_q);

  // Value that becomes active at the next apply point: a same-edge write beats the shadow.
  always_comb begin
    next_div  = div_act_q;
    next_mode = mode_q;
    if (we) begin
      next_div  = wdiv;
      next_mode = wmode;
    end else if (pend_q) begin
      next_div  = div_shd_q;
      next_mode = mode_shd_q;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_shd_d  = div_shd_q;
    mode_d     = mode_q;
    mode_shd_d = mode_shd_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    sq_d       = sq_q;

    if (!en || sync) begin
      cnt_d      = '0;
      sq_d       = 1'b0;
      div_act_d  = next_div;
      mode_d     = next_mode;
      div_shd_d  = next_div;
      mode_shd_d = next_mode;
      pend_d     = 1'b0;
    end else if (term) begin
      cnt_d      = '0;
      tick_d     = (mode_q == MODE_PULSE);
      // Toggle only if the channel stays in square mode; a mode switch restarts sq from 0.
      sq_d       = (mode_q == MODE_SQUARE) && (next_mode == MODE_SQUARE) && !sq_q;
      div_act_d  = next_div;
      mode_d     = next_mode;
      div_shd_d  = next_div;
      mode_shd_d = next_mode;
      pend_d     = 1'b0;
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (we) begin
        div_shd_d  = wdiv;
        mode_shd_d = wmode;
        pend_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q      <= '0;
      div_act_q  <= DEF_DIV;
      div_shd_q  <= DEF_DIV;
      mode_q     <= DEF_MODE;
      mode_shd_q <= DEF_MODE;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      sq_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_shd_q  <= div_shd_d;
      mode_q     <= mode_d;
      mode_shd_q <= mode_shd_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign pend = pend_q;

endmodule

// File: rtl/tick_gen_multi.sv
// N-channel programmable tick/clock-enable generator; decodes config writes to channels.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int unsigned        NCH      = 4,
  parameter int unsigned        CW       = DEF_CW,
  parameter logic [NCH*CW-1:0]  DEF_DIV  = {NCH{CW'(99999)}},
  parameter logic [NCH-1:0]     DEF_MODE = '0,
  localparam int unsigned       CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           mclk,
  input  logic           clr_n,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_mode,
  output logic [NCH-1:0] cfg_pend,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq
);

  logic [NCH-1:0] ch_we;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Out-of-range cfg_ch matches no channel and is dropped.
    assign ch_we[i] = cfg_we && (cfg_ch == CHW'(i));

    tick_gen_chan #(
      .CW       (CW),
      .DEF_DIV  (DEF_DIV[i*CW +: CW]),
      .DEF_MODE (DEF_MODE[i])
    ) u_chan (
      .mclk  (mclk),
      .clr_n (clr_n),
      .en    (en[i]),
      .sync  (sync),
      .we    (ch_we[i]),
      .wdiv  (cfg_div),
      .wmode (cfg_mode),
      .tick  (tick[i]),
      .sq    (sq[i]),
      .pend  (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: expected per-cycle outputs are queued, then popped and checked.
module tb_tick_gen_multi;

  logic        mclk = 1'b0;
  logic        clr_n;
  logic [3:0]  en;
  logic        sync;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic        cfg_mode;
  logic [3:0]  cfg_pend, tick, sq;

  logic [2:0]  en2;
  logic        cfg_we2;
  logic [1:0]  cfg_ch2;
  logic [7:0]  cfg_div2;
  logic        cfg_mode2;
  logic [2:0]  pend2, tick2, sq2;

  always #5 mclk = ~mclk;

  tick_gen_multi #(
    .NCH      (4),
    .CW       (32),
    .DEF_DIV  ({32'd3, 32'd5, 32'd5, 32'd3}),
    .DEF_MODE (4'b0000)
  ) dut (
    .mclk     (mclk),
    .clr_n    (clr_n),
    .en       (en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .cfg_pend (cfg_pend),
    .tick     (tick),
    .sq       (sq)
  );

  // Three-channel instance so that cfg_ch == NCH is representable.
  tick_gen_multi #(
    .NCH      (3),
    .CW       (8),
    .DEF_DIV  ({3{8'd2}}),
    .DEF_MODE (3'b000)
  ) dut2 (
    .mclk     (mclk),
    .clr_n    (clr_n),
    .en       (en2),
    .sync     (1'b0),
    .cfg_we   (cfg_we2),
    .cfg_ch   (cfg_ch2),
    .cfg_div  (cfg_div2),
    .cfg_mode (cfg_mode2),
    .cfg_pend (pend2),
    .tick     (tick2),
    .sq       (sq2)
  );

  typedef struct {
    string      tag;
    int         cyc;
    int         dut;
    int         ch;
    logic [2:0] exp;  // {tick, sq, pend}
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int off, input int d, input int ch,
                      input logic tk, input logic s, input logic p);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc + off;
    e.dut = d;
    e.ch  = ch;
    e.exp = {tk, s, p};
    sbq.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1;
      cyc++;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        exp_t e;
        logic [2:0] o;
        e = sbq.pop_front();
        if (e.dut == 0) o = {tick[e.ch], sq[e.ch], cfg_pend[e.ch]};
        else            o = {tick2[e.ch], sq2[e.ch], pend2[e.ch]};
        chk($sformatf("%s[ch%0d,c%0d]", e.tag, e.ch, e.cyc), {29'd0, o}, {29'd0, e.exp});
      end
    end
  endtask

  initial begin
    clr_n = 1'b0; en = '0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    en2 = '0; cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_div2 = '0; cfg_mode2 = 1'b0;

    // Reset state
    #2;
    chk("rst_tick", {28'd0, tick}, 32'd0);
    chk("rst_sq", {28'd0, sq}, 32'd0);
    chk("rst_pend", {28'd0, cfg_pend}, 32'd0);
    chk("rst_tick2", {29'd0, tick2}, 32'd0);
    run(2);

    // 1: ch0 default D=3 pulse, first tick 4 edges after en
    clr_n = 1'b1;
    en[0] = 1'b1;
    for (int k = 1; k <= 12; k++) push("t1_pulse", k, 0, 0, (k % 4 == 0), 1'b0, 1'b0);
    run(12);
    en[0] = 1'b0;

    // 2: ch1 square D=1 configured while disabled
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd1; cfg_mode = 1'b1;
    push("t2_cfg_dis", 1, 0, 1, 1'b0, 1'b0, 1'b0);
    run(1);
    cfg_we = 1'b0;
    en[1] = 1'b1;
    for (int k = 1; k <= 8; k++)
      push("t2_sq", k, 0, 1, 1'b0, (k % 4 == 2) || (k % 4 == 3), 1'b0);
    run(8);
    en[1] = 1'b0;

    // 3: ch2 D=9 running, rewrite to D=4 when cnt reaches 5
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd9; cfg_mode = 1'b0;
    run(1);
    cfg_we = 1'b0;
    for (int k = 1; k <= 21; k++)
      push("t3_pend", k, 0, 2, (k == 10) || (k == 15) || (k == 20), 1'b0, (k >= 5) && (k <= 9));
    en[2] = 1'b1;
    run(4);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd4; cfg_mode = 1'b0;
    run(1);
    cfg_we = 1'b0;
    run(16);
    en[2] = 1'b0;

    // 4: ch0 and ch3 out of phase, sync re-aligns them
    for (int k = 1; k <= 10; k++) begin
      push("t4_sync", k, 0, 0, (k == 4) || (k == 10), 1'b0, 1'b0);
      push("t4_sync", k, 0, 3, (k == 10), 1'b0, 1'b0);
    end
    en[0] = 1'b1;
    run(2);
    en[3] = 1'b1;
    run(3);
    sync = 1'b1;
    run(1);
    sync = 1'b0;
    run(4);

    // 5: pending write, then asynchronous clear between edges
    run(1);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd3; cfg_mode = 1'b0;
    push("t5_pend_set", 1, 0, 0, 1'b0, 1'b0, 1'b1);
    run(1);
    cfg_we = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    chk("t5_clr_tick", {28'd0, tick}, 32'd0);
    chk("t5_clr_sq", {28'd0, sq}, 32'd0);
    chk("t5_clr_pend", {28'd0, cfg_pend}, 32'd0);
    #1;
    clr_n = 1'b1;

    // 6: write landing on the terminal edge bypasses the shadow (D 3 -> 7)
    for (int k = 1; k <= 16; k++)
      push("t6_bypass", k, 0, 0, (k == 4) || (k == 8) || (k == 16), 1'b0, 1'b0);
    run(7);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd7; cfg_mode = 1'b0;
    run(1);
    cfg_we = 1'b0;
    run(8);

    // D=0 pulse: tick held high
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd0; cfg_mode = 1'b0;
    push("t6_d0_cfg", 1, 0, 2, 1'b0, 1'b0, 1'b0);
    run(1);
    cfg_we = 1'b0;
    en[2] = 1'b1;
    for (int k = 1; k <= 5; k++) push("t6_d0", k, 0, 2, 1'b1, 1'b0, 1'b0);
    run(5);
    en[2] = 1'b0;

    // cfg_ch == NCH on a 3-channel instance is ignored
    en2 = 3'b111;
    for (int k = 1; k <= 6; k++)
      for (int c = 0; c < 3; c++)
        push("t6_oob", k, 1, c, (k % 3 == 0), 1'b0, 1'b0);
    cfg_we2 = 1'b1; cfg_ch2 = 2'd3; cfg_div2 = 8'd0; cfg_mode2 = 1'b1;
    run(1);
    cfg_we2 = 1'b0;
    run(5);

    chk("sb_drain", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
